// File: rtl/inst_prefetch_ctrl_pkg.sv
// rtl/inst_prefetch_ctrl_pkg.sv - shared widths, constants and types for the instruction prefetcher
package inst_prefetch_ctrl_pkg;

  localparam int          INST_ADDR_W  = 32;
  localparam int          INST_W       = 32;
  localparam int          PF_DEPTH     = 4;
  localparam int          PF_CNT_W     = $clog2(PF_DEPTH) + 1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } pf_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } pf_entry_t;

  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_pf_fifo.sv
// rtl/inst_pf_fifo.sv - prefetch FIFO of {pc, inst} entries with push/pop/clear
module inst_pf_fifo
  import inst_prefetch_ctrl_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  pf_entry_t                 wdata_i,
  output logic                      valid_o,
  output pf_entry_t                 head_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  pf_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != DEPTH_C) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_prefetch_ctrl.sv
// rtl/inst_prefetch_ctrl.sv - fetch sequencer driving the instruction ROM and feeding IF/ID
module inst_prefetch_ctrl
  import inst_prefetch_ctrl_pkg::*;
#(
  parameter int          DEPTH    = PF_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce,
  output logic [INST_ADDR_W-1:0]   rom_addr,
  input  logic [INST_W-1:0]        rom_inst,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [INST_ADDR_W-1:0]   redirect_pc,
  output logic                     if_valid,
  output logic [INST_ADDR_W-1:0]   if_pc,
  output logic [INST_W-1:0]        if_inst,
  output logic [$clog2(DEPTH):0]   fetch_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  pf_state_e              state_q, state_d;
  logic [INST_ADDR_W-1:0] fpc_q, fpc_d;
  logic                   push, pop, clear;
  pf_entry_t              head;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    rom_ce   = CHIP_DISABLE;
    rom_addr = ZERO_WORD;
    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (redirect) begin
          clear = 1'b1;
          fpc_d = word_align(redirect_pc);
        end
      end
      default: begin
        // Redirect outranks everything: the queued entries belong to the wrong path.
        if (redirect) begin
          clear = 1'b1;
          fpc_d = word_align(redirect_pc);
        end else begin
          pop  = if_valid && !stall;
          push = (fetch_cnt < DEPTH_C) || pop;
          if (push) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = fpc_q;
            fpc_d    = fpc_q + 32'd4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_BOOT;
      fpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
    end
  end

  inst_pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ('{pc: fpc_q, inst: rom_inst}),
    .valid_o (if_valid),
    .head_o  (head),
    .count_o (fetch_cnt)
  );

  assign if_pc   = head.pc;
  assign if_inst = head.inst;

endmodule

// File: tb/tb_inst_prefetch_ctrl.sv
// tb/tb_inst_prefetch_ctrl.sv - directed self-checking bench for inst_prefetch_ctrl
module tb_inst_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [2:0]  fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  inst_prefetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce      (rom_ce),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  assign rom_inst = rom_addr >> 2;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Holds reset for two edges and releases it; the caller is then in the S_BOOT cycle.
  task automatic do_reset(input logic st);
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = st;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    step();
    n_cmp++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL rst_ce got %0h exp 0", rom_ce); end
    n_cmp++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", rom_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h exp 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin n_err++; $display("FAIL rst_if got pc %h inst %h exp 0/0", if_pc, if_inst); end
    n_cmp++; if (fetch_cnt !== 3'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", fetch_cnt); end
    redirect = 1'b0;
  endtask

  task automatic test_stream();
    do_reset(1'b0);
    n_cmp++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL stream_boot_ce got %0h exp 0", rom_ce); end
    step();
    n_cmp++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin n_err++; $display("FAIL stream_first_fetch got ce %0h addr %h exp 1/0", rom_ce, rom_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid got %0h exp 0", if_valid); end
    step();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4*i) || if_inst !== 32'(i) || fetch_cnt !== 3'd1)
        begin n_err++; $display("FAIL stream_%0d got v %0h pc %h inst %h cnt %0d exp 1/%h/%h/1", i, if_valid, if_pc, if_inst, fetch_cnt, 32'(4*i), 32'(i)); end
      step();
    end
  endtask

  task automatic test_stall_full();
    do_reset(1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rom_ce !== 1'b1 || rom_addr !== 32'(4*i) || fetch_cnt !== 3'(i))
        begin n_err++; $display("FAIL fill_%0d got ce %0h addr %h cnt %0d exp 1/%h/%0d", i, rom_ce, rom_addr, fetch_cnt, 32'(4*i), i); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rom_ce !== 1'b0 || rom_addr !== 32'h0 || fetch_cnt !== 3'd4 || if_pc !== 32'h0)
        begin n_err++; $display("FAIL full_hold_%0d got ce %0h addr %h cnt %0d pc %h exp 0/0/4/0", i, rom_ce, rom_addr, fetch_cnt, if_pc); end
      step();
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (rom_ce !== 1'b1 || rom_addr !== 32'h10 || if_pc !== 32'h0) begin n_err++; $display("FAIL full_pushpop got ce %0h addr %h pc %h exp 1/10/0", rom_ce, rom_addr, if_pc); end
    step();
    stall = 1'b1;
    #1;
    n_cmp++; if (fetch_cnt !== 3'd4 || if_pc !== 32'h4 || rom_ce !== 1'b0) begin n_err++; $display("FAIL full_after_pushpop got cnt %0d pc %h ce %0h exp 4/4/0", fetch_cnt, if_pc, rom_ce); end
    stall = 1'b0;
    #1;
    for (int i = 1; i < 6; i++) begin
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4*i) || if_inst !== 32'(i))
        begin n_err++; $display("FAIL drain_%0d got v %0h pc %h inst %h exp 1/%h/%h", i, if_valid, if_pc, if_inst, 32'(4*i), 32'(i)); end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    step(); step(); step(); step();
    n_cmp++; if (fetch_cnt !== 3'd3) begin n_err++; $display("FAIL redir_pre_cnt got %0d exp 3", fetch_cnt); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    n_cmp++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL redir_ce got %0h exp 0", rom_ce); end
    step();
    redirect = 1'b0; stall = 1'b0;
    #1;
    n_cmp++; if (if_valid !== 1'b0 || fetch_cnt !== 3'd0) begin n_err++; $display("FAIL redir_flush got v %0h cnt %0d exp 0/0", if_valid, fetch_cnt); end
    n_cmp++; if (rom_ce !== 1'b1 || rom_addr !== 32'h100) begin n_err++; $display("FAIL redir_target got ce %0h addr %h exp 1/100", rom_ce, rom_addr); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'h40) begin n_err++; $display("FAIL redir_head got v %0h pc %h inst %h exp 1/100/40", if_valid, if_pc, if_inst); end
    step();
    n_cmp++; if (if_pc !== 32'h104) begin n_err++; $display("FAIL redir_next got pc %h exp 104", if_pc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; stall = 1'b0;
    step();
    redirect = 1'b0;
    #1;
    n_cmp++; if (rom_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_fetch got %h exp fffffffc", rom_addr); end
    step();
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h3FFF_FFFF || rom_addr !== 32'h0) begin n_err++; $display("FAIL wrap_head got pc %h inst %h addr %h exp fffffffc/3fffffff/0", if_pc, if_inst, rom_addr); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin n_err++; $display("FAIL wrap_after got v %0h pc %h inst %h exp 1/0/0", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_boot_redirect();
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 32'h0000_0201;
    #1;
    n_cmp++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL boot_redir_ce got %0h exp 0", rom_ce); end
    step();
    redirect = 1'b0;
    #1;
    n_cmp++; if (rom_ce !== 1'b1 || rom_addr !== 32'h200) begin n_err++; $display("FAIL boot_redir_fetch got ce %0h addr %h exp 1/200", rom_ce, rom_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (fetch_cnt !== 3'd4) begin n_err++; $display("FAIL mid_full got %0d exp 4", fetch_cnt); end
    rst = 1'b0; stall = 1'b0;
    step();
    n_cmp++; if (if_valid !== 1'b0 || fetch_cnt !== 3'd0 || rom_ce !== 1'b0) begin n_err++; $display("FAIL mid_reset got v %0h cnt %0d ce %0h exp 0/0/0", if_valid, fetch_cnt, rom_ce); end
    rst = 1'b1;
    #1;
    n_cmp++; if (rom_ce !== 1'b0) begin n_err++; $display("FAIL mid_boot got ce %0h exp 0", rom_ce); end
    step();
    n_cmp++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin n_err++; $display("FAIL mid_restart got ce %0h addr %h exp 1/0", rom_ce, rom_addr); end
    step();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin n_err++; $display("FAIL mid_head got v %0h pc %h inst %h exp 1/0/0", if_valid, if_pc, if_inst); end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect();
    test_wrap();
    test_boot_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
